// File: rtl/bus_source_select_if.sv
// Bus-source request/select bundle between control (master) and the source encoder (slave).
interface bus_source_select_if #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5
);
  logic [NUM_SRC-1:0] src_req;
  logic               rr_mode;
  logic               hold;
  logic [SEL_W-1:0]   sel_out;
  logic               sel_valid;
  logic [NUM_SRC-1:0] grant;
  logic               conflict;
  logic [7:0]         conflict_cnt;

  modport master (
    output src_req, rr_mode, hold,
    input  sel_out, sel_valid, grant, conflict, conflict_cnt
  );

  modport slave (
    input  src_req, rr_mode, hold,
    output sel_out, sel_valid, grant, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_source_select.sv
// Registered bus-source encoder: fixed-priority or round-robin grant of one source,
// 1-cycle latency, hold freezes every register, multi-request conflicts flagged and counted.
module bus_source_select #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5
) (
  input  logic               clock,
  input  logic               clear,
  bus_source_select_if.slave bus
);

  localparam logic [NUM_SRC-1:0] REQ_ONE  = {{(NUM_SRC-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]   PTR_INIT = SEL_W'(NUM_SRC - 1);

  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               vld_q, vld_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               conf_q, conf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [NUM_SRC-1:0] req;
  logic               any_req;
  logic               found_lo, found_hi;
  logic [SEL_W-1:0]   win_lo, win_hi, winner;

  assign req     = bus.src_req;
  assign any_req = |req;

  // win_lo: lowest set bit overall; win_hi: lowest set bit strictly above ptr.
  // Round-robin takes win_hi when it exists, otherwise wraps to win_lo (ptr itself last).
  always_comb begin
    found_lo = 1'b0;
    found_hi = 1'b0;
    win_lo   = '0;
    win_hi   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = SEL_W'(i);
      end
      if (req[i] && !found_hi && (SEL_W'(i) > ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = SEL_W'(i);
      end
    end
    winner = (bus.rr_mode && found_hi) ? win_hi : win_lo;
  end

  always_comb begin
    conf_d  = |(req & (req - REQ_ONE));
    cnt_d   = (conf_d && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
    vld_d   = any_req;
    sel_d   = any_req ? winner : sel_q;
    ptr_d   = any_req ? winner : ptr_q;
    grant_d = any_req ? (REQ_ONE << winner) : '0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      sel_q   <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
      conf_q  <= 1'b0;
      cnt_q   <= 8'd0;
      ptr_q   <= PTR_INIT;
    end else if (!bus.hold) begin
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
      conf_q  <= conf_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.sel_out      = sel_q;
  assign bus.sel_valid    = vld_q;
  assign bus.grant        = grant_q;
  assign bus.conflict     = conf_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_source_select.sv
// Directed-vector bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_bus_source_select;

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic        vld;
    logic [23:0] grant;
    logic        conf;
    logic [7:0]  cnt;
  } exp_t;

  logic clock;
  logic clear;
  exp_t sb[$];
  int   total;
  int   bad;

  bus_source_select_if #(.NUM_SRC(24), .SEL_W(5)) bif ();

  bus_source_select #(.NUM_SRC(24), .SEL_W(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input string name, input int sel, input logic vld,
                              input logic [23:0] grant, input logic conf, input int cnt);
    exp_t e;
    e.name  = name;
    e.sel   = 5'(sel);
    e.vld   = vld;
    e.grant = grant;
    e.conf  = conf;
    e.cnt   = 8'(cnt);
    return e;
  endfunction

  // Apply inputs for one edge and queue the outputs expected right after it.
  task automatic drive(input logic clr, input logic hld, input logic mode,
                       input logic [23:0] req, input exp_t e);
    @(negedge clock);
    clear       = clr;
    bif.hold    = hld;
    bif.rr_mode = mode;
    bif.src_req = req;
    sb.push_back(e);
    @(posedge clock);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (bif.sel_out !== e.sel || bif.sel_valid !== e.vld || bif.grant !== e.grant ||
            bif.conflict !== e.conf || bif.conflict_cnt !== e.cnt) begin
          bad++;
          $display("FAIL %s: got sel=%0d vld=%0b grant=%h conf=%0b cnt=%0d, want sel=%0d vld=%0b grant=%h conf=%0b cnt=%0d",
                   e.name, bif.sel_out, bif.sel_valid, bif.grant, bif.conflict, bif.conflict_cnt,
                   e.sel, e.vld, e.grant, e.conf, e.cnt);
        end
      end
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    clear       = 1'b1;
    bif.hold    = 1'b1;
    bif.rr_mode = 1'b0;
    bif.src_req = 24'hFFFFFF;

    drive(1, 1, 0, 24'hFFFFFF, mk("reset0", 0, 0, 24'h0, 0, 0));
    drive(1, 1, 0, 24'hFFFFFF, mk("reset1", 0, 0, 24'h0, 0, 0));

    drive(0, 0, 0, 24'h000080, mk("fp_single7", 7, 1, 24'h000080, 0, 0));
    drive(0, 0, 0, 24'h900000, mk("fp_20_23", 20, 1, 24'h100000, 1, 1));
    drive(0, 0, 0, 24'h000000, mk("fp_idle", 20, 0, 24'h0, 0, 1));

    drive(1, 0, 0, 24'h000000, mk("reset_rr", 0, 0, 24'h0, 0, 0));
    drive(0, 0, 1, 24'h000005, mk("rr_a", 0, 1, 24'h000001, 1, 1));
    drive(0, 0, 1, 24'h000005, mk("rr_b", 2, 1, 24'h000004, 1, 2));
    drive(0, 0, 1, 24'h000005, mk("rr_c", 0, 1, 24'h000001, 1, 3));
    drive(0, 0, 1, 24'h000005, mk("rr_d", 2, 1, 24'h000004, 1, 4));

    drive(0, 0, 1, 24'h800000, mk("wrap_23", 23, 1, 24'h800000, 0, 4));
    drive(0, 0, 1, 24'h800001, mk("wrap_to0", 0, 1, 24'h000001, 1, 5));
    drive(0, 0, 1, 24'h800001, mk("wrap_back23", 23, 1, 24'h800000, 1, 6));
    drive(0, 0, 0, 24'h800001, mk("mode_fp_a", 0, 1, 24'h000001, 1, 7));
    drive(0, 0, 0, 24'h800001, mk("mode_fp_b", 0, 1, 24'h000001, 1, 8));

    drive(0, 0, 0, 24'h000060, mk("pre_hold5", 5, 1, 24'h000020, 1, 9));
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 24'h000200, mk("hold_frozen", 5, 1, 24'h000020, 1, 9));
    drive(0, 0, 0, 24'h000200, mk("hold_release9", 9, 1, 24'h000200, 0, 9));
    drive(1, 1, 0, 24'h000200, mk("clear_over_hold", 0, 0, 24'h0, 0, 0));

    drive(0, 0, 1, 24'h010000, mk("rr_single_a", 16, 1, 24'h010000, 0, 0));
    drive(0, 0, 1, 24'h010000, mk("rr_single_b", 16, 1, 24'h010000, 0, 0));
    drive(0, 0, 1, 24'h000000, mk("rr_idle", 16, 0, 24'h0, 0, 0));
    drive(0, 0, 1, 24'h010008, mk("rr_ptr_kept", 3, 1, 24'h000008, 1, 1));

    for (int i = 1; i <= 300; i++)
      drive(0, 0, 0, 24'h000003, mk("saturate", 0, 1, 24'h000001, 1, (i + 1 > 255) ? 255 : i + 1));

    repeat (3) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_source_select.md
# bus_source_select

Registered, parametrised bus-source encoder for the datapath bus multiplexer. It takes NUM_SRC one-hot-intended "drive bus" requests from control, grants exactly one, and presents a registered select code plus a one-hot grant. Two arbitration modes are supported: fixed priority (lowest index wins) and round-robin. Multiple simultaneous requests are flagged and counted for debug. The block drives the bus mux select lines in place of a purely combinational encoder.

## Interface
Parameters:
- NUM_SRC, default 24: number of bus sources. Legal range is 2..32. Index map: R0–R15 = 0–15, HI = 16, LO = 17, Zhigh = 18, Zlow = 19, PC = 20, MDR = 21, In_Port = 22, C = 23.
- SEL_W, default 5: select code width. Must be ≥ ceil(log2(NUM_SRC)).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- src_req  in  NUM_SRC  per-source drive request; bit i = source i.
- rr_mode  in  1  0 = fixed priority, 1 = round-robin.
- hold  in  1  freeze all state (select, grant, pointer, flags, counter).
- sel_out  out  SEL_W  registered index of the granted source.
- sel_valid  out  1  registered; 1 = a source was granted on the last evaluation.
- grant  out  NUM_SRC  registered one-hot of sel_out when sel_valid = 1; all zeros otherwise.
- conflict  out  1  registered; 1 = more than one src_req bit was set on the last evaluation.
- conflict_cnt  out  8  saturating count of evaluations with conflict.

## Operation
- Internal state: last-grant pointer `ptr` (SEL_W bits).
- Reset values (clear = 1):
  - sel_out = 0, sel_valid = 0, grant = 0, conflict = 0, conflict_cnt = 0, ptr = NUM_SRC-1.
- Priority: clear overrides hold and all other inputs.
- An evaluation occurs on every rising edge with clear = 0 and hold = 0.
- Fixed priority (rr_mode = 0):
  - winner = lowest index i with src_req[i] = 1.
- Round-robin (rr_mode = 1):
  - Search starts at ptr+1 and runs upward.
  - The search wraps from NUM_SRC-1 to 0.
  - The first set bit wins. ptr itself is checked last.
- When any request is set:
  - sel_out = winner, sel_valid = 1, grant = 1 << winner, ptr = winner. ptr updates in both modes.
- When no request is set:
  - sel_valid = 0 and grant = 0.
  - sel_out holds its previous value (the bus mux stays stable); ptr is unchanged.
- Conflict:
  - conflict = 1 when popcount(src_req) ≥ 2; otherwise 0.
  - conflict_cnt increments by 1 on each conflict evaluation and saturates at 255. It never wraps.
- Mode change: rr_mode is sampled per evaluation and takes effect on the same edge. ptr is retained across mode changes.
- Request bits at or above NUM_SRC do not exist. sel_out never exceeds NUM_SRC-1.

## Timing
- Latency: exactly 1 cycle. src_req sampled at edge k appears on the outputs after edge k.
- Outputs are purely registered. There is no combinational path from any input to any output.
- hold = 1 at edge k: every register keeps its value. While hold stays high, conflict keeps showing the last evaluated value and does not re-evaluate.
- Releasing hold: the first evaluation happens on the first edge with hold = 0, using src_req at that edge.
- clear asserted mid-stream: reset values appear after that edge.
- First evaluation after reset in round-robin mode searches starting from index 0.
- Single request held in round-robin mode: the same source is re-granted every cycle.

## Test plan
- Reset: clear = 1 for 2 cycles with src_req = 0xFFFFFF and hold = 1 → sel_out = 0, sel_valid = 0, grant = 0, conflict = 0, conflict_cnt = 0.
- Fixed priority:
  - src_req = 0x000080 → next cycle sel_out = 7, grant = 0x000080, sel_valid = 1, conflict = 0.
  - Then src_req = 0x900000 → sel_out = 20, conflict = 1, conflict_cnt = 1.
  - Then src_req = 0 → sel_valid = 0, sel_out = 20, grant = 0.
- Round-robin: after reset, rr_mode = 1 and src_req = 0x000005 held 4 cycles → sel_out sequence 0, 2, 0, 2; conflict = 1 each cycle; conflict_cnt = 4.
- Wrap-around (rr_mode = 1):
  - src_req = 0x800000 → sel_out = 23.
  - Then src_req = 0x800001 → sel_out = 0.
  - Then → sel_out = 23.
  - Switch to rr_mode = 0 with the same request → sel_out = 0 every cycle.
- Hold:
  - Grant sel_out = 5, then assert hold = 1 and change src_req to 0x000200 for 3 cycles → sel_out stays 5, sel_valid stays 1.
  - Release hold → next cycle sel_out = 9.
  - Assert clear while hold = 1 → reset values after that edge.
- Saturation: src_req = 0x000003 for 300 evaluations → conflict_cnt reaches 255 and stays at 255. sel_out = 0 throughout in fixed-priority mode.
